// File: rtl/readout_sequencer_pkg.sv
// Shared types and constants for the MPPC readout sequencer: FSM state
// encoding, default frame header and frame-length helpers.
package readout_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        WAIT_HI,
        WAIT_LO,
        NEXT
    } seq_state_t;

    localparam int         NCH_DEFAULT     = 8;
    localparam int         CW_DEFAULT      = 8;
    localparam logic [7:0] SYNC_DEFAULT    = 8'hA5;
    localparam int         BUSY_TO_DEFAULT = 15;
    localparam int         FRAME_LEN       = NCH_DEFAULT + 2;

    // Header byte + one byte per channel + XOR checksum byte.
    function automatic int frame_len(input int nch);
        return nch + 2;
    endfunction

endpackage

// File: rtl/readout_sequencer_if.sv
// Byte-wide write/busy handshake between the readout sequencer and the UART.
interface readout_sequencer_if #(
    parameter int CW = 8
);
    logic          uartWr;
    logic [CW-1:0] uartData;
    logic          uartBusy;

    modport master (output uartWr, output uartData, input uartBusy);
    modport slave  (input uartWr, input uartData, output uartBusy);
endinterface

// File: rtl/readout_sequencer_chan_counter.sv
// One discriminator channel: 2-flop synchroniser, registered rising-edge
// detect and a saturating event counter cleared on snapshot.
module readout_sequencer_chan_counter #(
    parameter int CW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          chIn,
    input  logic          en,
    input  logic          snap,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic sync1, sync2, prev, rise_q;

    // NOTE: every register here is updated with <= so the synchroniser and
    // edge stages shift by exactly one flop per clock regardless of order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            rise_q <= 1'b0;
            count  <= '0;
        end else begin
            sync1  <= chIn;
            sync2  <= sync1;
            prev   <= sync2;
            rise_q <= sync2 & ~prev;
            if (!en)
                count <= '0;
            else if (snap)
                // An edge landing in the snapshot cycle opens the new window.
                count <= {{(CW-1){1'b0}}, rise_q};
            else if (rise_q && count != CNT_MAX)
                count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/readout_sequencer.sv
// Counts MPPC discriminator edges per channel and, on each frame tick,
// snapshots the counters and streams one SYNC/data/XOR frame into the UART.
module readout_sequencer
    import readout_sequencer_pkg::*;
#(
    parameter int            NCH     = NCH_DEFAULT,
    parameter int            CW      = CW_DEFAULT,
    parameter logic [CW-1:0] SYNC    = CW'(SYNC_DEFAULT),
    parameter int            BUSY_TO = BUSY_TO_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NCH-1:0]         chIn,
    input  logic [NCH-1:0]         chMask,
    input  logic                   frameTick,
    readout_sequencer_if.master    bus,
    output logic                   frameActive,
    output logic                   overrun
);

    localparam int NBYTES = frame_len(NCH);
    localparam int IW     = $clog2(NBYTES);
    localparam int TW     = $clog2(BUSY_TO + 1);

    seq_state_t                  state;
    logic [IW-1:0]               idx;
    logic [TW-1:0]               timer;
    logic [NCH-1:0][CW-1:0]      count_w;
    logic [NCH-1:0][CW-1:0]      snap_q;
    logic [CW-1:0]               csum;
    logic [CW-1:0]               byte_sel;
    logic                        snap_go;

    assign snap_go = (state == IDLE) && frameTick;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        readout_sequencer_chan_counter #(.CW(CW)) u_chan (
            .CLK   (CLK),
            .RST   (RST),
            .chIn  (chIn[i]),
            .en    (chMask[i]),
            .snap  (snap_go),
            .count (count_w[i])
        );
    end

    // NOTE: both outputs get a default before any branch, so no latch is inferred.
    always_comb begin
        csum = '0;
        for (int i = 0; i < NCH; i++)
            csum = csum ^ snap_q[i];
        byte_sel = SYNC;
        if (idx == IW'(NBYTES - 1))
            byte_sel = csum;
        for (int i = 0; i < NCH; i++)
            if (idx == IW'(i + 1))
                byte_sel = snap_q[i];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            idx          <= '0;
            timer        <= '0;
            bus.uartWr   <= 1'b0;
            bus.uartData <= '0;
            frameActive  <= 1'b0;
            overrun      <= 1'b0;
            // NOTE: the snapshot bank is small and visible on the wire as frame
            // bytes, so it is reset like any other register.
            snap_q       <= '0;
        end else begin
            bus.uartWr <= 1'b0;
            if (frameTick && state != IDLE)
                overrun <= 1'b1;
            if (snap_go)
                snap_q <= count_w;

            case (state)
                IDLE: if (frameTick) begin
                    idx         <= '0;
                    frameActive <= 1'b1;
                    state       <= LOAD;
                end
                LOAD: begin
                    bus.uartData <= byte_sel;
                    state        <= STROBE;
                end
                STROBE: if (!bus.uartBusy) begin
                    bus.uartWr <= 1'b1;
                    timer      <= '0;
                    state      <= WAIT_HI;
                end
                WAIT_HI: begin
                    // A UART that never raises busy still lets the frame finish.
                    if (bus.uartBusy || timer == TW'(BUSY_TO - 1))
                        state <= WAIT_LO;
                    else
                        timer <= timer + TW'(1);
                end
                WAIT_LO: if (!bus.uartBusy)
                    state <= NEXT;
                NEXT: begin
                    if (idx == IW'(NBYTES - 1)) begin
                        frameActive <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        idx   <= idx + IW'(1);
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer: a UART model answers the write/busy
// handshake and every frame is compared byte-for-byte against hand values.
module tb_readout_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] chIn;
    logic [7:0] chMask;
    logic       frameTick;
    logic       frameActive;
    logic       overrun;

    readout_sequencer_if #(.CW(8)) u_if ();

    readout_sequencer u_dut (
        .CLK         (CLK),
        .RST         (RST),
        .chIn        (chIn),
        .chMask      (chMask),
        .frameTick   (frameTick),
        .bus         (u_if.master),
        .frameActive (frameActive),
        .overrun     (overrun)
    );

    always #5 CLK = ~CLK;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         rx_count = 0;
    logic [7:0] rx [32];
    int         strobe_cyc [32];
    bit         model_en = 1'b1;
    int         t = 0;

    always @(posedge CLK) cyc++;

    // Receiver: log every strobed byte and the cycle it was strobed in.
    always @(negedge CLK) begin
        if (u_if.uartWr && rx_count < 32) begin
            rx[rx_count]         = u_if.uartData;
            strobe_cyc[rx_count] = cyc;
            rx_count++;
        end
    end

    // UART model: busy rises two cycles after a strobe and lasts ten cycles.
    always @(negedge CLK) begin
        if (RST)
            t = 0;
        else if (u_if.uartWr)
            t = 1;
        else if (t != 0)
            t = (t == 13) ? 0 : t + 1;
        u_if.uartBusy = model_en && (t >= 3) && (t <= 12);
    end

    task automatic pulse_ch(input logic [7:0] ch, input int n);
        @(negedge CLK);
        for (int k = 0; k < n; k++) begin
            chIn = ch;
            repeat (2) @(negedge CLK);
            chIn = 8'h00;
            repeat (2) @(negedge CLK);
        end
        repeat (6) @(negedge CLK);
    endtask

    task automatic start_frame();
        rx_count = 0;
        @(negedge CLK);
        frameTick = 1'b1;
        @(negedge CLK);
        frameTick = 1'b0;
    endtask

    task automatic wait_frame(output bit timed_out);
        int n = 0;
        while (frameActive && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        timed_out = frameActive;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset();
        checks++; if (u_if.uartWr !== 1'b0) begin failures++; $display("FAIL reset_uartWr got=%b exp=0", u_if.uartWr); end
        checks++; if (u_if.uartData !== 8'h00) begin failures++; $display("FAIL reset_uartData got=%h exp=00", u_if.uartData); end
        checks++; if (frameActive !== 1'b0) begin failures++; $display("FAIL reset_frameActive got=%b exp=0", frameActive); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp [10] = '{8'hA5, 8'h03, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h06};
        bit to;
        pulse_ch(8'h01, 3);
        pulse_ch(8'h04, 5);
        start_frame();
        wait_frame(to);
        checks++; if (to) begin failures++; $display("FAIL basic_timeout frameActive stuck high"); end
        checks++; if (rx_count !== 10) begin failures++; $display("FAIL basic_strobes got=%0d exp=10", rx_count); end
        checks++; if (frameActive !== 1'b0) begin failures++; $display("FAIL basic_frameActive got=%b exp=0", frameActive); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx[i] !== exp[i]) begin failures++; $display("FAIL basic_byte%0d got=%h exp=%h", i, rx[i], exp[i]); end
        end
    endtask

    task automatic test_saturate();
        logic [7:0] exp [10] = '{8'hA5, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        bit to;
        pulse_ch(8'h02, 300);
        start_frame();
        wait_frame(to);
        checks++; if (to || rx_count !== 10) begin failures++; $display("FAIL sat_frame timeout=%b strobes=%0d exp=10", to, rx_count); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx[i] !== exp[i]) begin failures++; $display("FAIL sat_byte%0d got=%h exp=%h", i, rx[i], exp[i]); end
        end
    endtask

    task automatic test_mask();
        logic [7:0] masks [2] = '{8'hFE, 8'h01};
        logic [7:0] exp [2][10] = '{
            '{8'hA5, 8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04},
            '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04}};
        bit to;
        for (int m = 0; m < 2; m++) begin
            chMask = masks[m];
            pulse_ch(8'hFF, 4);
            start_frame();
            wait_frame(to);
            checks++; if (to || rx_count !== 10) begin failures++; $display("FAIL mask%0d_frame timeout=%b strobes=%0d exp=10", m, to, rx_count); end
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (rx[i] !== exp[m][i]) begin failures++; $display("FAIL mask%0d_byte%0d got=%h exp=%h", m, i, rx[i], exp[m][i]); end
            end
        end
        chMask = 8'hFF;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_snap_edge();
        bit to;
        // Rise before edge n reaches the counter at edge n+3: tick lands on that cycle.
        @(negedge CLK);
        chIn = 8'h08;
        repeat (3) @(negedge CLK);
        rx_count  = 0;
        frameTick = 1'b1;
        @(negedge CLK);
        frameTick = 1'b0;
        repeat (2) @(negedge CLK);
        chIn = 8'h00;
        wait_frame(to);
        checks++; if (to || rx_count !== 10) begin failures++; $display("FAIL snapedge_frame1 timeout=%b strobes=%0d exp=10", to, rx_count); end
        checks++; if (rx[4] !== 8'h00) begin failures++; $display("FAIL snapedge_ch3_first got=%h exp=00", rx[4]); end
        checks++; if (rx[9] !== 8'h00) begin failures++; $display("FAIL snapedge_csum_first got=%h exp=00", rx[9]); end
        start_frame();
        wait_frame(to);
        checks++; if (rx[4] !== 8'h01) begin failures++; $display("FAIL snapedge_ch3_next got=%h exp=01", rx[4]); end
        checks++; if (rx[9] !== 8'h01) begin failures++; $display("FAIL snapedge_csum_next got=%h exp=01", rx[9]); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp [10] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h02};
        bit to;
        int n = 0;
        start_frame();
        while (rx_count < 5 && n < 1000) begin @(negedge CLK); n++; end
        checks++; if (rx_count < 5) begin failures++; $display("FAIL ovr_reach_byte4 got=%0d exp=5", rx_count); end
        frameTick = 1'b1;
        @(negedge CLK);
        frameTick = 1'b0;
        pulse_ch(8'h20, 2);
        wait_frame(to);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        checks++; if (to || rx_count !== 10) begin failures++; $display("FAIL ovr_cur_frame timeout=%b strobes=%0d exp=10", to, rx_count); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx[i] !== ((i == 0) ? 8'hA5 : 8'h00)) begin failures++; $display("FAIL ovr_cur_byte%0d got=%h", i, rx[i]); end
        end
        repeat (30) @(negedge CLK);
        checks++; if (rx_count !== 10 || frameActive !== 1'b0) begin failures++; $display("FAIL ovr_no_extra strobes=%0d active=%b exp=10/0", rx_count, frameActive); end
        start_frame();
        wait_frame(to);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx[i] !== exp[i]) begin failures++; $display("FAIL ovr_next_byte%0d got=%h exp=%h", i, rx[i], exp[i]); end
        end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    endtask

    task automatic test_busy_low_and_reset();
        bit to;
        int n = 0;
        int seen = 0;
        int held;
        model_en = 1'b0;
        start_frame();
        wait_frame(to);
        checks++; if (to || rx_count !== 10) begin failures++; $display("FAIL bl_frame timeout=%b strobes=%0d exp=10", to, rx_count); end
        checks++; if (rx[0] !== 8'hA5 || rx[9] !== 8'h00) begin failures++; $display("FAIL bl_bytes got=%h/%h exp=a5/00", rx[0], rx[9]); end
        checks++; if (strobe_cyc[1] - strobe_cyc[0] !== 19) begin failures++; $display("FAIL bl_spacing01 got=%0d exp=19", strobe_cyc[1] - strobe_cyc[0]); end
        checks++; if (strobe_cyc[9] - strobe_cyc[8] !== 19) begin failures++; $display("FAIL bl_spacing89 got=%0d exp=19", strobe_cyc[9] - strobe_cyc[8]); end

        start_frame();
        while (seen < 6 && n < 1000) begin
            @(posedge CLK);
            #1;
            if (u_if.uartWr) seen++;
            n++;
        end
        checks++; if (seen !== 6) begin failures++; $display("FAIL rst_reach_byte5 got=%0d exp=6", seen); end
        RST = 1'b1;
        #1;
        checks++; if (u_if.uartWr !== 1'b0) begin failures++; $display("FAIL rst_mid_uartWr got=%b exp=0", u_if.uartWr); end
        checks++; if (frameActive !== 1'b0) begin failures++; $display("FAIL rst_mid_frameActive got=%b exp=0", frameActive); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_mid_overrun got=%b exp=0", overrun); end
        checks++; if (u_if.uartData !== 8'h00) begin failures++; $display("FAIL rst_mid_uartData got=%h exp=00", u_if.uartData); end
        repeat (3) @(negedge CLK);
        RST  = 1'b0;
        held = rx_count;
        repeat (60) @(negedge CLK);
        checks++; if (rx_count !== held || frameActive !== 1'b0) begin failures++; $display("FAIL rst_no_strobes strobes=%0d exp=%0d active=%b", rx_count, held, frameActive); end
    endtask

    initial begin
        RST           = 1'b1;
        chIn          = 8'h00;
        chMask        = 8'hFF;
        frameTick     = 1'b0;
        u_if.uartBusy = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        test_reset();
        test_basic_frame();
        test_saturate();
        test_mask();
        test_snap_edge();
        test_overrun();
        test_busy_low_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
